sum_serie: RTL and testbench

SUM_SERIE -- requirements
Module: sum_serie

---
 rtl/sum_serie.sv | 162 ++++++++++++++++
 tb/tb_sum_serie.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_serie.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | sum_serie : digit-serial adder, DIGIT bits per cycle, LSB slice first.    |
// | Optional SUM_SERIE_SUB_EN adds a 'sub' port selecting a - b.              |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module sum_serie #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SUM_SERIE_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int C_SLICES = (DIGIT < 1) ? 1 : (WIDTH / DIGIT);
    localparam int CNT_W    = (C_SLICES > 1) ? $clog2(C_SLICES) : 1;
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(C_SLICES - 1);

    if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
        $error("sum_serie: WIDTH must be a non-zero multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               msb_cin_q, msb_cin_d;
    logic               done_q, done_d;
    logic               c_out_q, c_out_d;
    logic               ovf_q, ovf_d;

    logic               w_sub;
    logic [DIGIT-1:0]   w_slice_sum;
    logic               w_slice_cout;
    logic               w_slice_msb_cin;

`ifdef SUM_SERIE_SUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    // One DIGIT-wide ripple on the low slice of the shifting operand registers.
    always_comb begin : p_ripple
        logic c;
        c               = carry_q;
        w_slice_sum     = '0;
        w_slice_msb_cin = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                w_slice_msb_cin = c;
            end
            w_slice_sum[i] = a_q[i] ^ b_q[i] ^ c;
            c              = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
        end
        w_slice_cout = c;
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        msb_cin_d = msb_cin_q;
        done_d    = 1'b0;
        c_out_d   = c_out_q;
        ovf_d     = ovf_q;

        case (state_q)
            RUN: begin
                for (int i = 0; i < C_SLICES; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        sum_d[i*DIGIT +: DIGIT] = w_slice_sum;
                    end
                end
                a_d       = a_q >> DIGIT;
                b_d       = b_q >> DIGIT;
                carry_d   = w_slice_cout;
                msb_cin_d = w_slice_msb_cin;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == C_LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                c_out_d = carry_q;
                ovf_d   = carry_q ^ msb_cin_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Acceptance in DONE allows back-to-back operation without a gap cycle.
        if ((state_q == IDLE || state_q == DONE) && start) begin
            a_d     = a;
            b_d     = w_sub ? ~b : b;
            carry_d = w_sub ? 1'b1 : c_in;
            cnt_d   = '0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            msb_cin_q <= 1'b0;
            done_q    <= 1'b0;
            c_out_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            msb_cin_q <= msb_cin_d;
            done_q    <= done_d;
            c_out_q   <= c_out_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_sum_serie.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sum_serie : self-checking bench for sum_serie (16/4 and 8/8 builds).   |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module tb_sum_serie;

    localparam int C_W = 16;
    localparam int C_N = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic [C_W-1:0] a = '0;
    logic [C_W-1:0] b = '0;
    logic c_in = 1'b0;
    logic sub = 1'b0;
    logic busy, done, c_out, ovf;
    logic [C_W-1:0] sum;

    logic start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic busy8, done8, c_out8, ovf8;
    logic [7:0] sum8;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sum_serie #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b), .c_in(c_in),
`ifdef SUM_SERIE_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    sum_serie #(.WIDTH(8), .DIGIT(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8), .c_in(1'b0),
`ifdef SUM_SERIE_SUB_EN
        .sub(1'b0),
`endif
        .busy(busy8), .done(done8), .sum(sum8), .c_out(c_out8), .ovf(ovf8)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: arithmetic result per accepted request, due N+1 edges later.
    typedef struct {
        int             due;
        logic [C_W-1:0] s;
        logic           c;
        logic           o;
    } exp_t;

    exp_t           exp_q[$];
    int             cyc = 0;
    int             phase = 0;
    bit             seen_rst = 1'b0;
    logic           exp_done = 1'b0;
    logic [C_W-1:0] last_s = '0;
    logic           last_c = 1'b0;
    logic           last_o = 1'b0;

    always @(posedge clk) begin
        exp_t           e;
        logic [C_W-1:0] be;
        logic [C_W:0]   full;
        logic           ci;
        cyc++;
        if (!reset_n) begin
            seen_rst = 1'b1;
            phase    = 0;
            exp_q.delete();
            exp_done = 1'b0;
            last_s   = '0;
            last_c   = 1'b0;
            last_o   = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e        = exp_q.pop_front();
                exp_done = 1'b1;
                last_s   = e.s;
                last_c   = e.c;
                last_o   = e.o;
            end
            if ((phase == 0 || phase == 1) && start) begin
`ifdef SUM_SERIE_SUB_EN
                be = sub ? ~b : b;
                ci = sub ? 1'b1 : c_in;
`else
                be = b;
                ci = c_in;
`endif
                full  = {1'b0, a} + {1'b0, be} + {{C_W{1'b0}}, ci};
                e.due = cyc + C_N + 1;
                e.s   = full[C_W-1:0];
                e.c   = full[C_W];
                e.o   = (a[C_W-1] == be[C_W-1]) && (full[C_W-1] != a[C_W-1]);
                exp_q.push_back(e);
                phase = C_N + 1;
            end else if (phase > 0) begin
                phase--;
            end
        end
    end

    always @(negedge clk) begin
        if (seen_rst) begin
            check("busy", {31'b0, busy}, {31'b0, (phase != 0)});
            check("done", {31'b0, done}, {31'b0, exp_done});
            check("c_out", {31'b0, c_out}, {31'b0, last_c});
            check("ovf", {31'b0, ovf}, {31'b0, last_o});
            if (exp_done || phase == 0) begin
                check("sum", {16'b0, sum}, {16'b0, last_s});
            end
        end
    end

    task automatic run_op(input logic [C_W-1:0] ta, input logic [C_W-1:0] tb_v,
                          input logic tc, input logic ts,
                          input logic [C_W-1:0] es, input logic ec, input logic eo,
                          input string nm, input bit poke);
        int lat;
        @(negedge clk);
        a = ta; b = tb_v; c_in = tc; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = ~tb_v; c_in = ~tc;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            if (poke && k == 1) begin
                start = 1'b1;
                a = 16'hAAAA;
                b = 16'h5555;
            end
            if (k == 2) start = 1'b0;
        end
        start = 1'b0;
        check({nm, "_latency"}, lat, C_N + 1);
        check({nm, "_sum"}, {16'b0, sum}, {16'b0, es});
        check({nm, "_c_out"}, {31'b0, c_out}, {31'b0, ec});
        check({nm, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int ndone;
        int lat8;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_sum", {16'b0, sum}, 32'd0);
        check("rst_c_out", {31'b0, c_out}, 32'd0);
        check("rst_ovf", {31'b0, ovf}, 32'd0);
        reset_n = 1'b1;

        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "carry8", 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap", 1'b0);
        run_op(16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, "cin_ign_start", 1'b1);
        run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, "sgn_ovf", 1'b0);

        // Abort in the second RUN cycle; start raised with reset must be ignored.
        @(negedge clk);
        a = 16'h5555; b = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b0; start = 1'b1; a = 16'h0F0F;
        @(posedge clk);
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_sum", {16'b0, sum}, 32'd0);
        check("abort_c_out", {31'b0, c_out}, 32'd0);
        check("abort_ovf", {31'b0, ovf}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1; start = 1'b0;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, "after_abort", 1'b0);

`ifdef SUM_SERIE_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow", 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf", 1'b0);
        sub = 1'b0;
`endif

        // Start held high with fresh operands every cycle.
        @(negedge clk);
        start = 1'b1;
        ndone = 0;
        repeat (16) begin
            @(negedge clk);
            if (done) ndone++;
            a = 16'($urandom);
            b = 16'($urandom);
            c_in = 1'($urandom);
        end
        start = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("b2b_done_count", ndone, 4);

        // Single-slice build: WIDTH equals DIGIT.
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        lat8 = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (done8) begin
                lat8 = k;
                break;
            end
        end
        check("w8_latency", lat8, 2);
        check("w8_sum", {24'b0, sum8}, 32'h00);
        check("w8_c_out", {31'b0, c_out8}, 32'd1);
        check("w8_ovf", {31'b0, ovf8}, 32'd1);
        @(posedge clk);
        #1;
        check("w8_done_pulse", {31'b0, done8}, 32'd0);
        check("w8_busy_idle", {31'b0, busy8}, 32'd0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
